// File: rtl/sap_pkg.sv
// Shared definitions for the SAP instruction sequencer: one-hot T-states and IR geometry.
package sap_pkg;

  localparam int IR_W  = 8;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

endpackage

// File: rtl/ring_counter_6.sv
// Six-state one-hot T-state rotator with hold, freeze and jump-to-T1 controls.
module ring_counter_6
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       jump_t1,
  input  logic       freeze,
  output logic [5:0] tstate
);

  tstate_e r_state;
  tstate_e w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= T1;
    end else begin
      r_state <= w_next;
    end
  end

  // freeze outranks jump_t1 so a halt in T4 wins over an early end.
  always_comb begin
    w_next = r_state;
    if (advance && !freeze) begin
      if (jump_t1) begin
        w_next = T1;
      end else begin
        case (r_state)
          T1:      w_next = T2;
          T2:      w_next = T3;
          T3:      w_next = T4;
          T4:      w_next = T5;
          T5:      w_next = T6;
          T6:      w_next = T1;
          default: w_next = T1;
        endcase
      end
    end
  end

  assign tstate = r_state;

endmodule

// File: rtl/instr_sequencer.sv
// SAP-style instruction sequencer: T-state ring, instruction register and sticky halt.
// Optional macro SAP_EARLY_DONE_EN adds instr_done to end an instruction in T4/T5.
module instr_sequencer
  import sap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IR_W-1:0]  bus_in,
`ifdef SAP_EARLY_DONE_EN
  input  logic             instr_done,
`endif
  output logic [OPC_W-1:0] opcode,
  output logic [OPC_W-1:0] operand,
  output logic [5:0]       tstate,
  output logic             fetch,
  output logic             ir_load,
  output logic             halted
);

  logic [IR_W-1:0] r_ir;
  logic            r_halted;
  logic [5:0]      w_tstate;
  logic            w_hlt;
  logic            w_jump_t1;
  logic            w_advance;
  logic            w_freeze;

  assign w_hlt = run && !r_halted && (w_tstate == T4) && (r_ir[IR_W-1:OPC_W] == OPC_HLT);

`ifdef SAP_EARLY_DONE_EN
  assign w_jump_t1 = run && instr_done && ((w_tstate == T4) || (w_tstate == T5));
`else
  assign w_jump_t1 = 1'b0;
`endif

  assign w_advance = run && !r_halted;
  assign w_freeze  = r_halted || w_hlt;

  ring_counter_6 u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (w_advance),
    .jump_t1 (w_jump_t1),
    .freeze  (w_freeze),
    .tstate  (w_tstate)
  );

  assign fetch   = (w_tstate == T1) || (w_tstate == T2) || (w_tstate == T3);
  assign ir_load = run && (w_tstate == T3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir     <= '0;
      r_halted <= 1'b0;
    end else begin
      if (ir_load) begin
        r_ir <= bus_in;
      end
      if (w_hlt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign opcode  = r_ir[IR_W-1:OPC_W];
  assign operand = r_ir[OPC_W-1:0];
  assign tstate  = w_tstate;
  assign halted  = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a T-state-index reference model checked every cycle.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] bus_in;
  logic       instr_done;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [5:0] tstate;
  logic       fetch;
  logic       ir_load;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_t;
  logic [7:0] m_ir;
  logic       m_h;
  bit         cmp_en = 1'b0;

`ifdef SAP_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .bus_in     (bus_in),
`ifdef SAP_EARLY_DONE_EN
    .instr_done (instr_done),
`endif
    .opcode     (opcode),
    .operand    (operand),
    .tstate     (tstate),
    .fetch      (fetch),
    .ir_load    (ir_load),
    .halted     (halted)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: T-state as an index 0..5 (T1..T6).
  always @(posedge clk) begin
    if (rst) begin
      m_t  = 0;
      m_ir = 8'h00;
      m_h  = 1'b0;
    end else if (run && !m_h) begin
      if (m_t == 3 && m_ir[7:4] == 4'hF) begin
        m_h = 1'b1;
      end else if (EARLY && instr_done && (m_t == 3 || m_t == 4)) begin
        m_t = 0;
      end else begin
        if (m_t == 2) m_ir = bus_in;
        m_t = (m_t + 1) % 6;
      end
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tstate",  {2'b00, tstate}, {2'b00, 6'(1 << m_t)});
      chk("m_opcode",  {4'h0, opcode},  {4'h0, m_ir[7:4]});
      chk("m_operand", {4'h0, operand}, {4'h0, m_ir[3:0]});
      chk("m_fetch",   {7'h0, fetch},   {7'h0, (m_t < 3)});
      chk("m_ir_load", {7'h0, ir_load}, {7'h0, (m_t == 2 && run)});
      chk("m_halted",  {7'h0, halted},  {7'h0, m_h});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; bus_in = 8'h00; instr_done = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_tstate",  {2'b00, tstate}, 8'h01);
    chk("rst_opcode",  {4'h0, opcode},  8'h00);
    chk("rst_operand", {4'h0, operand}, 8'h00);
    chk("rst_halted",  {7'h0, halted},  8'h00);
    chk("rst_fetch",   {7'h0, fetch},   8'h01);
    chk("rst_ir_load", {7'h0, ir_load}, 8'h00);

    // Fetch 0x1E, full six-state instruction
    run = 1'b1; bus_in = 8'h1E;
    tick(2);
    chk("t3_tstate",  {2'b00, tstate}, 8'h04);
    chk("t3_ir_load", {7'h0, ir_load}, 8'h01);
    chk("t3_opcode_old", {4'h0, opcode}, 8'h00);
    tick(1);
    bus_in = 8'h00;
    chk("t4_tstate",  {2'b00, tstate}, 8'h08);
    chk("t4_opcode",  {4'h0, opcode},  8'h01);
    chk("t4_operand", {4'h0, operand}, 8'h0E);
    tick(3);
    chk("wrap_tstate", {2'b00, tstate}, 8'h01);
    chk("wrap_fetch",  {7'h0, fetch},   8'h01);

    // Stall in T2
    tick(1);
    run = 1'b0;
    tick(3);
    chk("stall_tstate", {2'b00, tstate}, 8'h02);
    run = 1'b1;
    tick(1);
    chk("resume_tstate", {2'b00, tstate}, 8'h04);

    // Stalled in T3: no load, ir_load low
    run = 1'b0; bus_in = 8'h77;
    tick(1);
    chk("stall_t3_ir_load", {7'h0, ir_load}, 8'h00);
    chk("stall_t3_opcode",  {4'h0, opcode},  8'h01);

    // Halt
    run = 1'b1; bus_in = 8'hF0;
    tick(1);
    chk("hlt_opcode", {4'h0, opcode}, 8'h0F);
    chk("hlt_pre",    {7'h0, halted}, 8'h00);
    tick(1);
    chk("hlt_set",    {7'h0, halted}, 8'h01);
    chk("hlt_tstate", {2'b00, tstate}, 8'h08);
    instr_done = 1'b1;
    tick(6);
    run = 1'b0;
    tick(6);
    instr_done = 1'b0;
    chk("hlt_hold_tstate", {2'b00, tstate}, 8'h08);
    chk("hlt_hold_flag",   {7'h0, halted},  8'h01);
    rst = 1'b1; run = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("hlt_clr_flag",   {7'h0, halted},  8'h00);
    chk("hlt_clr_tstate", {2'b00, tstate}, 8'h01);
    chk("hlt_clr_opcode", {4'h0, opcode},  8'h00);

    // Reset mid-instruction in T5 with instr_done asserted
    bus_in = 8'h25;
    tick(4);
    chk("mid_t5_tstate", {2'b00, tstate}, 8'h10);
    chk("mid_t5_opcode", {4'h0, opcode},  8'h02);
    rst = 1'b1; instr_done = 1'b1;
    tick(1);
    rst = 1'b0; instr_done = 1'b0;
    chk("mid_rst_tstate",  {2'b00, tstate}, 8'h01);
    chk("mid_rst_operand", {4'h0, operand}, 8'h00);

`ifdef SAP_EARLY_DONE_EN
    // Early done: ignored in T2, honoured in T4 and T5
    tick(1);
    instr_done = 1'b1;
    tick(1);
    chk("ed_t2_ignored", {2'b00, tstate}, 8'h04);
    instr_done = 1'b0; bus_in = 8'h3A;
    tick(1);
    instr_done = 1'b1;
    tick(1);
    chk("ed_t4_jump", {2'b00, tstate}, 8'h01);
    instr_done = 1'b0;
    tick(4);
    instr_done = 1'b1;
    tick(1);
    chk("ed_t5_jump", {2'b00, tstate}, 8'h01);
    instr_done = 1'b0; bus_in = 8'hF1;
    tick(3);
    instr_done = 1'b1;
    tick(1);
    chk("ed_hlt_wins_flag",   {7'h0, halted},  8'h01);
    chk("ed_hlt_wins_tstate", {2'b00, tstate}, 8'h08);
    instr_done = 1'b0;
`else
    // Without early done every instruction is six T-states
    bus_in = 8'h3A;
    instr_done = 1'b1;
    tick(4);
    chk("noed_t5", {2'b00, tstate}, 8'h10);
    tick(2);
    chk("noed_t1", {2'b00, tstate}, 8'h01);
    instr_done = 1'b0;
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
